// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the squeeze controller state encoding.
package keccak_pkg;

    localparam int unsigned BW_STATE        = 1600;
    localparam int unsigned BW_LANE         = 64;
    localparam int unsigned N_LANES         = 25;
    localparam int unsigned RATE_W_SHAKE128 = 21;
    localparam int unsigned RATE_W_SHAKE256 = 17;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_REQ,
        SQ_WAIT,
        SQ_OUT
    } squeeze_state_t;

    // Index of the last rate lane for the selected SHAKE variant.
    function automatic logic [4:0] last_rate_lane(input logic mode);
        return mode ? 5'(RATE_W_SHAKE256 - 1) : 5'(RATE_W_SHAKE128 - 1);
    endfunction

endpackage

// File: rtl/keccak_lane_sel.sv
// 25:1 lane multiplexer; lane i sits at the top of the state vector downwards.
module keccak_lane_sel
    import keccak_pkg::*;
#(
    parameter int unsigned BW_DATA = BW_STATE,
    parameter int unsigned BW_WORD = BW_LANE
) (
    input  logic [BW_DATA-1:0] state,
    input  logic [4:0]         lane_idx,
    output logic [BW_WORD-1:0] lane
);

    // Pick lane lane_idx; indices past the last lane read as zero.
    always_comb begin
        lane = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (lane_idx == 5'(i)) begin
                lane = state[BW_DATA-1-BW_WORD*i -: BW_WORD];
            end
        end
    end

endmodule

// File: rtl/keccak_squeeze.sv
// SHAKE squeeze controller: permutes the absorbed state through an external
// keccakf1600 core and streams rate lanes as 64-bit words.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int unsigned BW_DATA = BW_STATE,
    parameter int unsigned BW_WORD = BW_LANE,
    parameter int unsigned BW_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic [BW_CNT-1:0]  i_nwords,
    input  logic [BW_DATA-1:0] i_state,
    output logic [BW_DATA-1:0] o_perm_state,
    output logic               o_perm_valid,
    input  logic [BW_DATA-1:0] i_perm_state,
    input  logic               i_perm_valid,
    output logic [BW_WORD-1:0] o_word,
    output logic               o_word_valid,
    input  logic               i_word_ready,
    output logic               o_busy,
    output logic               o_done
);

    squeeze_state_t     fsm_q;
    logic [BW_DATA-1:0] state_q;
    logic [4:0]         lane_idx;
    logic [BW_CNT-1:0]  remaining;
    logic               mode_q;
    logic               handshake;

    assign handshake    = o_word_valid & i_word_ready;
    assign o_perm_state = state_q;

    keccak_lane_sel #(
        .BW_DATA (BW_DATA),
        .BW_WORD (BW_WORD)
    ) u_lane_sel (
        .state    (state_q),
        .lane_idx (lane_idx),
        .lane     (o_word)
    );

    // Squeeze FSM; strobes and status flags are registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q        <= SQ_IDLE;
            state_q      <= '0;
            lane_idx     <= '0;
            remaining    <= '0;
            mode_q       <= 1'b0;
            o_perm_valid <= 1'b0;
            o_word_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_perm_valid <= 1'b0;
            o_done       <= 1'b0;
            case (fsm_q)
                SQ_IDLE: begin
                    if (i_start) begin
                        if (i_nwords != '0) begin
                            state_q      <= i_state;
                            remaining    <= i_nwords;
                            mode_q       <= i_mode;
                            lane_idx     <= '0;
                            fsm_q        <= SQ_REQ;
                            o_perm_valid <= 1'b1;
                            o_busy       <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                SQ_REQ: begin
                    fsm_q <= SQ_WAIT;
                end
                SQ_WAIT: begin
                    if (i_perm_valid) begin
                        state_q      <= i_perm_state;
                        lane_idx     <= '0;
                        fsm_q        <= SQ_OUT;
                        o_word_valid <= 1'b1;
                    end
                end
                SQ_OUT: begin
                    if (handshake) begin
                        remaining <= remaining - BW_CNT'(1);
                        if (remaining == BW_CNT'(1)) begin
                            fsm_q        <= SQ_IDLE;
                            o_word_valid <= 1'b0;
                            o_busy       <= 1'b0;
                            o_done       <= 1'b1;
                        end else if (lane_idx == last_rate_lane(mode_q)) begin
                            fsm_q        <= SQ_REQ;
                            o_word_valid <= 1'b0;
                            o_perm_valid <= 1'b1;
                        end else begin
                            lane_idx <= lane_idx + 5'd1;
                        end
                    end
                end
                default: fsm_q <= SQ_IDLE;
            endcase
        end
    end

endmodule
